// File: rtl/text_memory_ctrl.sv
// text_memory_ctrl: COLS x ROWS text-mode cell memory with a registered display
// read port, a handshaked host write port and a fill engine for clear/scroll.
// Ports:
//   clk, reset (async, active-low)
//   load_char, xtext, ytext -> rd_data           display read (1-cycle latency)
//   wr_valid/wr_ready, xtextwrite, ytextwrite, value   host cell write
//   cmd_valid/cmd_ready, cmd_op, fill_value      clear / scroll / reset-scroll / no-op
//   busy, scroll_row                             fill engine status, row offset
module text_memory_ctrl #(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 30,
    parameter int unsigned DATA_W = 24,
    parameter int unsigned XW     = $clog2(COLS),
    parameter int unsigned YW     = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_char,
    input  logic [XW-1:0]     xtext,
    input  logic [YW-1:0]     ytext,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [XW-1:0]     xtextwrite,
    input  logic [YW-1:0]     ytextwrite,
    input  logic [DATA_W-1:0] value,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic [YW-1:0]     scroll_row
);

    localparam int unsigned CELLS = COLS * ROWS;
    localparam int unsigned AW    = $clog2(CELLS);

    localparam logic [XW:0]   COLS_X      = (XW+1)'(COLS);
    localparam logic [YW:0]   ROWS_Y      = (YW+1)'(ROWS);
    localparam logic [YW-1:0] LAST_SCROLL = YW'(ROWS - 1);
    localparam logic [AW-1:0] LAST_ALL    = AW'(CELLS - 1);
    localparam logic [AW-1:0] LAST_ROW    = AW'(COLS - 1);
    localparam logic [AW-1:0] COLS_A      = AW'(COLS);

    localparam logic [1:0] OP_CLEAR  = 2'b00;
    localparam logic [1:0] OP_SCROLL = 2'b01;
    localparam logic [1:0] OP_RST_SC = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL_ALL,
        ST_FILL_ROW
    } state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]       base_q, base_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic [YW-1:0]       scroll_q, scroll_d;
    logic [DATA_W-1:0]   rd_data_q;

    logic                mem_we_c;
    logic [AW-1:0]       mem_addr_c;
    logic [DATA_W-1:0]   mem_wdata_c;
    logic [AW-1:0]       raddr_c;
    logic                rd_ok_c;
    logic                wr_ok_c;

    logic [DATA_W-1:0]   mem_q [CELLS];

    // Logical row -> physical row through the circular offset, then linear address.
    function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] x,
                                                input logic [YW-1:0] y,
                                                input logic [YW-1:0] off);
        logic [YW:0] sum;
        sum = {1'b0, y} + {1'b0, off};
        if (sum >= ROWS_Y) begin
            sum = sum - ROWS_Y;
        end
        return AW'(sum) * COLS_A + AW'(x);
    endfunction

    assign raddr_c = cell_addr(xtext, ytext, scroll_q);
    assign rd_ok_c = ({1'b0, xtext} < COLS_X) && ({1'b0, ytext} < ROWS_Y);
    assign wr_ok_c = ({1'b0, xtextwrite} < COLS_X) && ({1'b0, ytextwrite} < ROWS_Y);

    // State register and fill-engine context.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            base_q   <= '0;
            fill_q   <= '0;
            scroll_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            fill_q   <= fill_d;
            scroll_q <= scroll_d;
        end
    end

    // Next-state, handshakes and the shared write-port mux.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        fill_d      = fill_q;
        scroll_d    = scroll_q;
        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                // A pending command blocks the host write in the same cycle.
                wr_ready  = !cmd_valid;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_CLEAR: begin
                            fill_d   = fill_value;
                            scroll_d = '0;
                            cnt_d    = '0;
                            state_d  = ST_FILL_ALL;
                        end
                        OP_SCROLL: begin
                            // Old top row becomes the new bottom row; blank it.
                            fill_d   = fill_value;
                            base_d   = AW'(scroll_q) * COLS_A;
                            scroll_d = (scroll_q == LAST_SCROLL) ? '0 : scroll_q + 1'b1;
                            cnt_d    = '0;
                            state_d  = ST_FILL_ROW;
                        end
                        OP_RST_SC: begin
                            scroll_d = '0;
                        end
                        default: begin
                        end
                    endcase
                end else if (wr_valid && wr_ok_c) begin
                    mem_we_c    = 1'b1;
                    mem_addr_c  = cell_addr(xtextwrite, ytextwrite, scroll_q);
                    mem_wdata_c = value;
                end
            end
            ST_FILL_ALL: begin
                mem_we_c    = 1'b1;
                mem_addr_c  = cnt_q;
                mem_wdata_c = fill_q;
                if (cnt_q == LAST_ALL) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FILL_ROW: begin
                mem_we_c    = 1'b1;
                mem_addr_c  = base_q + cnt_q;
                mem_wdata_c = fill_q;
                if (cnt_q == LAST_ROW) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write port; storage is never reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_addr_c] <= mem_wdata_c;
        end
    end

    // Registered display read; out-of-range coordinates read as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else if (load_char) begin
            rd_data_q <= rd_ok_c ? mem_q[raddr_c] : '0;
        end
    end

    assign rd_data    = rd_data_q;
    assign busy       = (state_q != ST_IDLE);
    assign scroll_row = scroll_q;

endmodule

// File: tb/tb_text_memory_ctrl.sv
// Directed testbench for text_memory_ctrl (80x30, 24-bit cells).
module tb_text_memory_ctrl;

    logic        clk;
    logic        reset;
    logic        load_char;
    logic [6:0]  xtext;
    logic [4:0]  ytext;
    logic [23:0] rd_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [6:0]  xtextwrite;
    logic [4:0]  ytextwrite;
    logic [23:0] value;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [23:0] fill_value;
    logic        busy;
    logic [4:0]  scroll_row;

    int vectors;
    int miscompares;

    text_memory_ctrl #(
        .COLS   (80),
        .ROWS   (30),
        .DATA_W (24)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_char  (load_char),
        .xtext      (xtext),
        .ytext      (ytext),
        .rd_data    (rd_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .xtextwrite (xtextwrite),
        .ytextwrite (ytextwrite),
        .value      (value),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .fill_value (fill_value),
        .busy       (busy),
        .scroll_row (scroll_row)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic host_write(input int x, input int y, input logic [23:0] v);
        wr_valid   = 1'b1;
        xtextwrite = 7'(x);
        ytextwrite = 5'(y);
        value      = v;
        @(negedge clk);
        wr_valid   = 1'b0;
    endtask

    task automatic read_cell(input int x, input int y, output logic [23:0] d);
        load_char = 1'b1;
        xtext     = 7'(x);
        ytext     = 5'(y);
        @(negedge clk);
        load_char = 1'b0;
        d         = rd_data;
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [23:0] fv);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        fill_value = fv;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    // Counts falling edges with busy high (bounded); flags any ready seen while busy.
    task automatic wait_idle(output int cycles, output logic ready_seen);
        cycles     = 0;
        ready_seen = 1'b0;
        while (busy && cycles < 5000) begin
            if (wr_ready || cmd_ready) ready_seen = 1'b1;
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (rd_data !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_rd_data actual=%h required=%h", rd_data, 24'h0);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy actual=%b required=0", busy);
        end
        vectors++;
        if (scroll_row !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_scroll_row actual=%0d required=0", scroll_row);
        end
        vectors++;
        if (wr_ready !== 1'b1 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready actual wr=%b cmd=%b required 1 1", wr_ready, cmd_ready);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        logic [23:0] d;
        host_write(4, 2, 24'hABCDEF);
        host_write(3, 2, 24'h123456);
        read_cell(3, 2, d);
        vectors++;
        if (d !== 24'h123456) begin
            miscompares++;
            $display("FAIL write_then_read actual=%h required=%h", d, 24'h123456);
        end
        read_cell(4, 2, d);
        vectors++;
        if (d !== 24'hABCDEF) begin
            miscompares++;
            $display("FAIL neighbour_cell actual=%h required=%h", d, 24'hABCDEF);
        end
        // Hold while load_char low even as coordinates move.
        xtext = 7'd3;
        repeat (2) @(negedge clk);
        vectors++;
        if (rd_data !== 24'hABCDEF) begin
            miscompares++;
            $display("FAIL read_hold actual=%h required=%h", rd_data, 24'hABCDEF);
        end
        // Same-cycle read and write of one cell returns the old word.
        load_char  = 1'b1;
        xtext      = 7'd3;
        ytext      = 5'd2;
        host_write(3, 2, 24'h654321);
        load_char  = 1'b0;
        vectors++;
        if (rd_data !== 24'h123456) begin
            miscompares++;
            $display("FAIL read_before_write actual=%h required=%h", rd_data, 24'h123456);
        end
        read_cell(3, 2, d);
        vectors++;
        if (d !== 24'h654321) begin
            miscompares++;
            $display("FAIL write_after_collision actual=%h required=%h", d, 24'h654321);
        end
    endtask

    task automatic test_clear();
        int cyc;
        int bad;
        logic seen;
        logic [23:0] d;
        logic [23:0] first_bad;
        issue_cmd(2'b01, 24'h0);
        wait_idle(cyc, seen);
        vectors++;
        if (scroll_row !== 5'd1) begin
            miscompares++;
            $display("FAIL pre_clear_scroll actual=%0d required=1", scroll_row);
        end
        issue_cmd(2'b00, 24'h000020);
        vectors++;
        if (scroll_row !== 5'd0) begin
            miscompares++;
            $display("FAIL clear_scroll_row actual=%0d required=0", scroll_row);
        end
        wait_idle(cyc, seen);
        vectors++;
        if (cyc !== 2400) begin
            miscompares++;
            $display("FAIL clear_busy_cycles actual=%0d required=2400", cyc);
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_ready_while_busy actual=%b required=0", seen);
        end
        bad = 0;
        first_bad = 24'h0;
        for (int y = 0; y < 30; y++) begin
            for (int x = 0; x < 80; x++) begin
                read_cell(x, y, d);
                if (d !== 24'h000020) begin
                    if (bad == 0) first_bad = d;
                    bad++;
                end
            end
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL clear_cells actual=%0d bad cells (first %h) required=0 bad", bad, first_bad);
        end
    endtask

    task automatic test_scroll();
        int cyc;
        logic seen;
        logic [23:0] d;
        for (int y = 0; y < 30; y++) begin
            for (int x = 0; x < 80; x++) begin
                host_write(x, y, 24'(y));
            end
        end
        issue_cmd(2'b01, 24'h0000FF);
        vectors++;
        if (scroll_row !== 5'd1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL scroll_start actual scroll=%0d busy=%b required 1 1", scroll_row, busy);
        end
        wait_idle(cyc, seen);
        vectors++;
        if (cyc !== 80 || seen !== 1'b0) begin
            miscompares++;
            $display("FAIL scroll_busy_cycles actual=%0d ready_seen=%b required=80 0", cyc, seen);
        end
        read_cell(0, 0, d);
        vectors++;
        if (d !== 24'd1) begin
            miscompares++;
            $display("FAIL scroll_row0_col0 actual=%h required=%h", d, 24'd1);
        end
        read_cell(79, 0, d);
        vectors++;
        if (d !== 24'd1) begin
            miscompares++;
            $display("FAIL scroll_row0_col79 actual=%h required=%h", d, 24'd1);
        end
        read_cell(0, 29, d);
        vectors++;
        if (d !== 24'h0000FF) begin
            miscompares++;
            $display("FAIL scroll_row29_col0 actual=%h required=%h", d, 24'h0000FF);
        end
        read_cell(79, 29, d);
        vectors++;
        if (d !== 24'h0000FF) begin
            miscompares++;
            $display("FAIL scroll_row29_col79 actual=%h required=%h", d, 24'h0000FF);
        end
        read_cell(0, 28, d);
        vectors++;
        if (d !== 24'd29) begin
            miscompares++;
            $display("FAIL scroll_row28 actual=%h required=%h", d, 24'd29);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        logic seen;
        logic [23:0] d;
        issue_cmd(2'b10, 24'h0);
        vectors++;
        if (scroll_row !== 5'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_scroll actual scroll=%0d busy=%b required 0 0", scroll_row, busy);
        end
        read_cell(5, 0, d);
        vectors++;
        if (d !== 24'h0000FF) begin
            miscompares++;
            $display("FAIL phys_row0_filled actual=%h required=%h", d, 24'h0000FF);
        end
        for (int i = 0; i < 29; i++) begin
            issue_cmd(2'b01, 24'h0000FF);
            wait_idle(cyc, seen);
        end
        vectors++;
        if (scroll_row !== 5'd29) begin
            miscompares++;
            $display("FAIL scroll_29 actual=%0d required=29", scroll_row);
        end
        issue_cmd(2'b01, 24'h0000FF);
        vectors++;
        if (scroll_row !== 5'd0) begin
            miscompares++;
            $display("FAIL scroll_wrap actual=%0d required=0", scroll_row);
        end
        wait_idle(cyc, seen);
        issue_cmd(2'b01, 24'h0000FF);
        wait_idle(cyc, seen);
        host_write(0, 0, 24'h5A5A5A);
        issue_cmd(2'b10, 24'h0);
        read_cell(0, 1, d);
        vectors++;
        if (d !== 24'h5A5A5A) begin
            miscompares++;
            $display("FAIL offset_write_phys1 actual=%h required=%h", d, 24'h5A5A5A);
        end
        read_cell(0, 0, d);
        vectors++;
        if (d !== 24'h0000FF) begin
            miscompares++;
            $display("FAIL offset_write_phys0 actual=%h required=%h", d, 24'h0000FF);
        end
    endtask

    task automatic test_conflict_and_range();
        logic [23:0] d;
        host_write(5, 5, 24'h111111);
        cmd_valid  = 1'b1;
        cmd_op     = 2'b11;
        wr_valid   = 1'b1;
        xtextwrite = 7'd5;
        ytextwrite = 5'd5;
        value      = 24'h777777;
        #1;
        vectors++;
        if (wr_ready !== 1'b0 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL conflict_ready actual wr=%b cmd=%b required 0 1", wr_ready, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        read_cell(5, 5, d);
        vectors++;
        if (d !== 24'h111111 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL conflict_write_dropped actual=%h busy=%b required=%h 0", d, busy, 24'h111111);
        end
        host_write(0, 1, 24'h222222);
        host_write(0, 0, 24'h333333);
        wr_valid   = 1'b1;
        xtextwrite = 7'd80;
        ytextwrite = 5'd0;
        value      = 24'h999999;
        #1;
        vectors++;
        if (wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL oor_x_accept actual=%b required=1", wr_ready);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        host_write(0, 30, 24'h999999);
        read_cell(0, 1, d);
        vectors++;
        if (d !== 24'h222222) begin
            miscompares++;
            $display("FAIL oor_x_no_alias actual=%h required=%h", d, 24'h222222);
        end
        read_cell(80, 0, d);
        vectors++;
        if (d !== 24'h0) begin
            miscompares++;
            $display("FAIL oor_x_read actual=%h required=%h", d, 24'h0);
        end
        read_cell(0, 0, d);
        vectors++;
        if (d !== 24'h333333) begin
            miscompares++;
            $display("FAIL oor_y_no_alias actual=%h required=%h", d, 24'h333333);
        end
        read_cell(0, 30, d);
        vectors++;
        if (d !== 24'h0) begin
            miscompares++;
            $display("FAIL oor_y_read actual=%h required=%h", d, 24'h0);
        end
    endtask

    task automatic test_reset_mid_fill();
        int bad;
        logic [23:0] d;
        host_write(20, 1, 24'h444444);
        load_char = 1'b1;
        xtext     = 7'd20;
        ytext     = 5'd1;
        issue_cmd(2'b00, 24'hABCABC);
        repeat (100) @(posedge clk);
        #2;
        vectors++;
        if (rd_data !== 24'h444444) begin
            miscompares++;
            $display("FAIL pre_abort_read actual=%h required=%h", rd_data, 24'h444444);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || rd_data !== 24'h0 || scroll_row !== 5'd0) begin
            miscompares++;
            $display("FAIL abort_state actual busy=%b rd=%h scroll=%0d required 0 0 0", busy, rd_data, scroll_row);
        end
        load_char = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            read_cell(i % 80, i / 80, d);
            if (d !== 24'hABCABC) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL abort_filled_cells actual=%0d bad required=0 bad", bad);
        end
        read_cell(20, 1, d);
        vectors++;
        if (d !== 24'h444444) begin
            miscompares++;
            $display("FAIL abort_cell100 actual=%h required=%h", d, 24'h444444);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        load_char   = 1'b0;
        xtext       = '0;
        ytext       = '0;
        wr_valid    = 1'b0;
        xtextwrite  = '0;
        ytextwrite  = '0;
        value       = '0;
        cmd_valid   = 1'b0;
        cmd_op      = 2'b11;
        fill_value  = '0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_clear();
        test_scroll();
        test_wrap();
        test_conflict_and_range();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/text_memory_ctrl.md
# text_memory_ctrl

Parametrised text-mode video memory controller: a COLS×ROWS grid of character/attribute words with a registered display read port and a handshaked host write port. A fill engine clears the screen or scrolls it in hardware through a circular row offset. It sits between the host/command logic and the character generator pipeline, and replaces the fixed-size memory with a free-running `clk_load_char` clock. Attribute field splitting stays downstream.

## Interface
- `COLS`, 80, text columns (≥2)
- `ROWS`, 30, text rows (≥2)
- `DATA_W`, 24, character+attribute word width
- `XW`, $clog2(COLS), column coordinate width
- `YW`, $clog2(ROWS), row coordinate width
- `clk` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-low.
- `load_char` in 1: display read enable, sampled on `clk`.
- `xtext` in XW: display column.
- `ytext` in YW: display logical row.
- `rd_data` out DATA_W: registered cell word.
- `wr_valid` in 1: host write request.
- `wr_ready` out 1: write accepted when `wr_valid` and `wr_ready` are both high.
- `xtextwrite` in XW: write column.
- `ytextwrite` in YW: write logical row.
- `value` in DATA_W: write data.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when `cmd_valid` and `cmd_ready` are both high.
- `cmd_op` in 2: command code.
  - 00: clear screen.
  - 01: scroll up one row.
  - 10: reset scroll to 0.
  - 11: no-op.
- `fill_value` in DATA_W: word written by clear and scroll, sampled at command accept.
- `busy` out 1: fill engine active.
- `scroll_row` out YW: current physical index of logical row 0.

## Operation
- Storage: COLS*ROWS words, dual-ported.
  - Port A: display read only.
  - Port B: write only, shared by host and fill engine.
- Reset affects no storage contents.
- Address mapping: phys_row = (logical_row + scroll_row) mod ROWS, computed without overflow at YW+1 bits. Address = phys_row*COLS + x.
- Out-of-range coordinates (x ≥ COLS or y ≥ ROWS):
  - Reads return 0.
  - Writes are accepted (handshake completes) and dropped.
- States: IDLE, FILL_ALL, FILL_ROW.
  - IDLE:
    - `cmd_ready`=1.
    - `wr_ready` = !`cmd_valid`. A command wins any same-cycle conflict.
  - Accept of clear: latch `fill_value`, scroll_row←0, counter←0, enter FILL_ALL.
  - Accept of scroll: latch `fill_value`. Row to clear = old scroll_row. scroll_row ← (scroll_row+1) mod ROWS. Enter FILL_ROW.
  - Accept of reset-scroll: scroll_row←0, stay IDLE. No-op: stay IDLE.
  - FILL_ALL: write one word per cycle to addresses 0..COLS*ROWS−1. After the last write, return to IDLE.
  - FILL_ROW: write one word per cycle to the COLS addresses of the cleared physical row, column 0 first. After the last write, return to IDLE.
- While not IDLE: `busy`=1, `wr_ready`=0, `cmd_ready`=0. Display reads continue at full rate.
- Display reads during a fill may return old or new words for a cell. This tearing is acceptable.

## Timing
- Reset values:
  - `rd_data`=0, `busy`=0, `scroll_row`=0.
  - State IDLE, so `wr_ready`=1 and `cmd_ready`=1 (with `cmd_valid` low).
- Read latency:
  - `rd_data` is updated on the `clk` edge where `load_char`=1, using that cycle's `xtext`/`ytext` and `scroll_row`.
  - Valid from the next cycle. Held while `load_char`=0.
- Write latency: a host write accepted at edge N is visible to a read sampled at edge N+1.
- Same-cycle read and write to the same cell returns the old word (read-before-write).
- Command at edge N:
  - `busy` high from N+1.
  - Clear: COLS*ROWS write cycles, `busy` low after edge N+COLS*ROWS.
  - Scroll: COLS write cycles, `busy` low after edge N+COLS.
  - `scroll_row` changes at edge N.
- Scroll wrap: scroll_row = ROWS−1 followed by a scroll gives 0.
- Reset asserted mid-fill:
  - Abort immediately and go to IDLE.
  - Partially filled contents remain.
  - `scroll_row`=0.

## Test plan
- Reset, host writes 0x123456 to (3,2), then a read of (3,2) one cycle later → `rd_data`=0x123456; a read of (4,2) returns its prior contents.
- Clear with `fill_value`=0x000020 → `busy` high for exactly 2400 cycles (80×30); `wr_ready` low throughout; every cell then reads 0x000020; `scroll_row`=0.
- Write row tags (row r = r), then scroll → `scroll_row`=1; logical row 0 reads tag 1; logical row 29 reads the fill value; `busy` lasts 80 cycles.
- 30 consecutive scrolls → `scroll_row` wraps 29→0; a write to logical (0,0) lands in the physical row matching the current offset.
- `cmd_valid` and `wr_valid` asserted in the same IDLE cycle → command accepted, write not accepted (`wr_ready`=0). Then x=80 write → accepted, no cell changes; read of y=30 → 0.
- Reset pulsed 100 cycles into a clear → `busy`=0 and `rd_data`=0 immediately; cells 0..99 hold the fill value, cell 100 onward unchanged.
